// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit: opcodes, step states,
// bus-select codes and ALU operation codes.
package proc_pkg;

  localparam int unsigned NREG_DEF  = 8;
  localparam int unsigned IR_W_DEF  = 9;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned OPC_W     = 3;
  localparam int unsigned BUS_SEL_W = 4;
  localparam int unsigned ALU_OP_W  = 2;

  localparam logic [OPC_W-1:0] OP_MV  = 3'b000;
  localparam logic [OPC_W-1:0] OP_MVI = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b011;
  localparam logic [OPC_W-1:0] OP_AND = 3'b100;

  localparam logic [BUS_SEL_W-1:0] SEL_G    = 4'd8;
  localparam logic [BUS_SEL_W-1:0] SEL_DIN  = 4'd9;
  localparam logic [BUS_SEL_W-1:0] SEL_NONE = 4'd15;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // ALU operation for an arithmetic/logic opcode; add for anything else.
  function automatic logic [ALU_OP_W-1:0] alu_of(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_ir_decode.sv
// Instruction field decoder (purely combinational).
// Ports: ir in; opcode/rx/ry fields, one-hot rx, is_alu/is_illegal flags out.
module proc_ir_decode
  import proc_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned IR_W = IR_W_DEF
) (
  input  logic [IR_W-1:0]      ir,
  output logic [OPC_W-1:0]     opcode,
  output logic [REG_IDX_W-1:0] rx,
  output logic [REG_IDX_W-1:0] ry,
  output logic [NREG-1:0]      rx_oh,
  output logic                 is_alu,
  output logic                 is_illegal
);

  // Field split {opcode, rx, ry} and opcode classification.
  always_comb begin
    opcode     = ir[8:6];
    rx         = ir[5:3];
    ry         = ir[2:0];
    is_alu     = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
    is_illegal = !(is_alu || (opcode == OP_MV) || (opcode == OP_MVI));
    for (int i = 0; i < int'(NREG); i++) begin
      rx_oh[i] = (rx == REG_IDX_W'(i));
    end
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Control unit for the 16-bit processor datapath: fetches one instruction per
// run request and sequences IR, R0..R7, A, G, ALU and the bus mux in T0..T3.
// Ports: clock, reset (sync, active-high), run, ir in;
//        ir_in, r_in (one-hot), a_in, g_in, alu_op, bus_sel, busy, done out.
// Outputs are decoded combinationally from the step, ir and run.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned IR_W = IR_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [IR_W-1:0]      ir,
  output logic                 ir_in,
  output logic [NREG-1:0]      r_in,
  output logic                 a_in,
  output logic                 g_in,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic [BUS_SEL_W-1:0] bus_sel,
  output logic                 busy,
  output logic                 done
);

  state_t                state;
  state_t                state_nxt;
  logic [OPC_W-1:0]      opcode;
  logic [REG_IDX_W-1:0]  rx;
  logic [REG_IDX_W-1:0]  ry;
  logic [NREG-1:0]       rx_oh;
  logic                  is_alu;
  logic                  is_illegal;

  proc_ir_decode #(
    .NREG (NREG),
    .IR_W (IR_W)
  ) u_decode (
    .ir         (ir),
    .opcode     (opcode),
    .rx         (rx),
    .ry         (ry),
    .rx_oh      (rx_oh),
    .is_alu     (is_alu),
    .is_illegal (is_illegal)
  );

  // Step register.
  always_ff @(posedge clock) begin
    if (reset) state <= T0;
    else       state <= state_nxt;
  end

  // Next step and per-step control decode.
  always_comb begin
    state_nxt = state;
    ir_in     = 1'b0;
    r_in      = '0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    alu_op    = ALU_ADD;
    bus_sel   = SEL_NONE;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      T0: begin
        if (run) begin
          ir_in     = 1'b1;
          bus_sel   = SEL_DIN;
          state_nxt = T1;
        end
      end
      T1: begin
        busy = 1'b1;
        if (is_illegal) begin
          done      = 1'b1;
          state_nxt = T0;
        end else if (is_alu) begin
          bus_sel   = {1'b0, rx};
          a_in      = 1'b1;
          state_nxt = T2;
        end else begin
          // mv reads Ry; mvi takes the immediate presented on DIN this step.
          bus_sel   = (opcode == OP_MVI) ? SEL_DIN : {1'b0, ry};
          r_in      = rx_oh;
          done      = 1'b1;
          state_nxt = T0;
        end
      end
      T2: begin
        busy      = 1'b1;
        bus_sel   = {1'b0, ry};
        g_in      = 1'b1;
        alu_op    = alu_of(opcode);
        state_nxt = T3;
      end
      T3: begin
        busy      = 1'b1;
        bus_sel   = SEL_G;
        r_in      = rx_oh;
        done      = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase

    // Reset masks every enable so nothing half-finished lands on that edge.
    if (reset) begin
      state_nxt = T0;
      ir_in     = 1'b0;
      r_in      = '0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      alu_op    = ALU_ADD;
      bus_sel   = SEL_NONE;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: a small datapath driven by the control outputs,
// an instruction-level expectation queue for the control outputs, and an
// ISA-level register-file model checked after every cycle.
module tb_proc_control_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b0;
  logic [15:0] din   = 16'h0;
  logic [8:0]  ir_q  = 9'h0;

  logic        ir_in;
  logic [7:0]  r_in;
  logic        a_in;
  logic        g_in;
  logic [1:0]  alu_op;
  logic [3:0]  bus_sel;
  logic        busy;
  logic        done;

  proc_control_fsm dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .ir      (ir_q),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .alu_op  (alu_op),
    .bus_sel (bus_sel),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  // Datapath: registers, A/G, ALU and bus mux steered by the control unit.
  logic [15:0] dreg [8] = '{default: 16'h0};
  logic [15:0] areg = 16'h0;
  logic [15:0] greg = 16'h0;
  logic [15:0] bus;
  logic [15:0] alu;

  always_comb begin
    case (bus_sel)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: bus = dreg[bus_sel[2:0]];
      4'd8:    bus = greg;
      4'd9:    bus = din;
      default: bus = 16'h0;
    endcase
    case (alu_op)
      2'b00:   alu = areg + bus;
      2'b01:   alu = areg - bus;
      2'b10:   alu = areg & bus;
      default: alu = 16'h0;
    endcase
  end

  always @(posedge clock) begin
    if (ir_in) ir_q <= din[8:0];
    if (a_in)  areg <= bus;
    if (g_in)  greg <= alu;
    for (int i = 0; i < 8; i++) if (r_in[i]) dreg[i] <= bus;
  end

  // Expected control outputs of one cycle, plus retirement info.
  typedef struct packed {
    logic       ir_in;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic [1:0] alu_op;
    logic [3:0] bus_sel;
    logic       busy;
    logic       done;
    logic       fin;
    logic [8:0] word;
  } step_t;

  step_t       q[$];
  logic [15:0] mreg [8] = '{default: 16'h0};
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic step_t idle_step();
    step_t s;
    s = '0;
    s.bus_sel = 4'd15;
    return s;
  endfunction

  // Queue the post-fetch steps of an instruction, straight from the ISA table.
  function automatic void plan(input logic [8:0] w);
    step_t      s;
    logic [2:0] op;
    logic [7:0] dst;
    op  = w[8:6];
    dst = 8'd1 << w[5:3];
    s = idle_step();
    s.busy = 1'b1;
    s.word = w;
    case (op)
      3'd0, 3'd1: begin
        s.bus_sel = (op == 3'd0) ? {1'b0, w[2:0]} : 4'd9;
        s.r_in = dst; s.done = 1'b1; s.fin = 1'b1;
        q.push_back(s);
      end
      3'd2, 3'd3, 3'd4: begin
        s.bus_sel = {1'b0, w[5:3]}; s.a_in = 1'b1;
        q.push_back(s);
        s = idle_step(); s.busy = 1'b1; s.word = w;
        s.bus_sel = {1'b0, w[2:0]}; s.g_in = 1'b1;
        s.alu_op = (op == 3'd2) ? 2'b00 : (op == 3'd3) ? 2'b01 : 2'b10;
        q.push_back(s);
        s = idle_step(); s.busy = 1'b1; s.word = w;
        s.bus_sel = 4'd8; s.r_in = dst; s.done = 1'b1; s.fin = 1'b1;
        q.push_back(s);
      end
      default: begin
        s.done = 1'b1; s.fin = 1'b1;
        q.push_back(s);
      end
    endcase
  endfunction

  // Architectural effect of a completed instruction.
  function automatic void retire(input logic [8:0] w, input logic [15:0] d);
    logic [2:0] rx, ry;
    rx = w[5:3];
    ry = w[2:0];
    case (w[8:6])
      3'd0: mreg[rx] = mreg[ry];
      3'd1: mreg[rx] = d;
      3'd2: mreg[rx] = mreg[rx] + mreg[ry];
      3'd3: mreg[rx] = mreg[rx] - mreg[ry];
      3'd4: mreg[rx] = mreg[rx] & mreg[ry];
      default: ;
    endcase
  endfunction

  function automatic logic [18:0] pack(input step_t s);
    return {s.ir_in, s.r_in, s.a_in, s.g_in, s.alu_op, s.bus_sel, s.busy, s.done};
  endfunction

  function automatic logic [127:0] dp_regs();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = dreg[i];
    return v;
  endfunction

  function automatic logic [127:0] model_regs();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = mreg[i];
    return v;
  endfunction

  // One clock cycle: drive, predict, check outputs mid-cycle, check regs after the edge.
  task automatic cyc(input logic r, input logic [15:0] d, input logic rs);
    step_t e;
    run   = r;
    din   = d;
    reset = rs;
    e = idle_step();
    if (rs) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (r) begin
        e.ir_in = 1'b1;
        e.bus_sel = 4'd9;
        plan(d[8:0]);
      end
    end else begin
      e = q.pop_front();
      if (e.fin) retire(e.word, d);
    end
    @(negedge clock);
    chk("ctrl_outs", 128'(pack(e)),
        128'({ir_in, r_in, a_in, g_in, alu_op, bus_sel, busy, done}));
    @(posedge clock);
    #1;
    chk("reg_file", dp_regs(), model_regs());
  endtask

  function automatic logic [15:0] fetch(input logic [8:0] w);
    return {7'($urandom), w};
  endfunction

  initial begin
    @(posedge clock);
    #1;

    // Reset, then idle with run low.
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'($urandom), 1'b0);

    // mvi R1,#5 ; mvi R3,#7 ; add R1,R3 -> R1 = 12
    cyc(1'b1, fetch(9'b001_001_000), 1'b0);
    cyc(1'b0, 16'd5, 1'b0);
    cyc(1'b1, fetch(9'b001_011_000), 1'b0);
    cyc(1'b0, 16'd7, 1'b0);
    cyc(1'b1, fetch(9'b010_001_011), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'($urandom), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    chk("add_r1_r3", 128'(dreg[1]), 128'd12);

    // mvi R0,#0x1234 ; sub R0,R0 -> 0
    cyc(1'b1, fetch(9'b001_000_000), 1'b0);
    cyc(1'b0, 16'h1234, 1'b0);
    cyc(1'b1, fetch(9'b011_000_000), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'($urandom), 1'b0);
    chk("sub_r0_r0", 128'(dreg[0]), 128'd0);

    // mvi R2 with a random immediate
    cyc(1'b1, fetch(9'b001_010_000), 1'b0);
    cyc(1'b0, 16'($urandom), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);

    // Illegal opcode is a two-cycle no-op.
    cyc(1'b1, fetch(9'b111_101_110), 1'b0);
    cyc(1'b0, 16'($urandom), 1'b0);

    // Reset during T2 of add R4,R5 leaves R4 untouched.
    cyc(1'b1, fetch(9'b001_100_000), 1'b0);
    cyc(1'b0, 16'd100, 1'b0);
    cyc(1'b1, fetch(9'b001_101_000), 1'b0);
    cyc(1'b0, 16'd3, 1'b0);
    cyc(1'b1, fetch(9'b010_100_101), 1'b0);
    cyc(1'b0, 16'($urandom), 1'b0);
    cyc(1'b0, 16'($urandom), 1'b1);
    cyc(1'b0, 16'($urandom), 1'b0);
    cyc(1'b0, 16'($urandom), 1'b0);
    chk("reset_in_t2", 128'(dreg[4]), 128'd100);

    // run held high through three mv instructions: done on cycles 1, 3, 5.
    cyc(1'b1, fetch(9'b000_110_001), 1'b0);
    cyc(1'b1, 16'($urandom), 1'b0);
    cyc(1'b1, fetch(9'b000_111_010), 1'b0);
    cyc(1'b1, 16'($urandom), 1'b0);
    cyc(1'b1, fetch(9'b000_011_011), 1'b0);
    cyc(1'b1, 16'($urandom), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);

    // Random instruction stream with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Control unit for the 16-bit processor datapath.
- Sequences the instruction register, the general registers R0..R7, the A/G accumulator registers, the ALU and the shared bus mux.
- Fetches one 9-bit instruction per `run` pulse, walks a T0..T3 step FSM, and drives one-hot register enables, the bus select and `done`.
- Sits between external `run`/`DIN` and the register/ALU/bus-mux instances.

Parameters:
- NREG, 8, number of general registers (register index width fixed at 3 bits).
- IR_W, 9, instruction width: {opcode[8:6], rx[5:3], ry[2:0]}.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  start request; sampled only in T0.
- `ir`  in  IR_W  output of the instruction register (loaded via `ir_in`).
- `ir_in`  out  1  instruction register enable (IR captures DIN).
- `r_in`  out  NREG  one-hot general-register write enables.
- `a_in`  out  1  A register enable.
- `g_in`  out  1  G register enable.
- `alu_op`  out  2  00 add, 01 sub, 10 and.
- `bus_sel`  out  4  0-7 = R0..R7, 8 = G, 9 = DIN, 15 = none (bus drives 0).
- `busy`  out  1  high in T1..T3.
- `done`  out  1  one-cycle pulse in the final step of each instruction.

Behaviour:
- State register holds T0, T1, T2, T3.
- Outputs are combinational from state, `ir` and `run`.
- While `reset` = 1, all outputs are forced to 0 and `bus_sel` = 15.
- The first edge with `reset` high sets state to T0 in any state. No partial write completes after that edge.
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#DIN
  - 010 add
  - 011 sub
  - 100 and
  - 101-111 illegal.
- Step outputs:
  - T0:
    - `run` = 0: all enables 0, `bus_sel` = 15, stay in T0.
    - `run` = 1: `ir_in` = 1, `bus_sel` = 9; next state T1. IR captures DIN on that edge.
  - T1, mv: `bus_sel` = ry, `r_in[rx]` = 1, `done` = 1 -> T0.
  - T1, mvi: `bus_sel` = 9, `r_in[rx]` = 1, `done` = 1 -> T0. Immediate is presented on DIN in T1.
  - T1, add/sub/and: `bus_sel` = rx, `a_in` = 1 -> T2.
  - T1, illegal: no enables, `bus_sel` = 15, `done` = 1 -> T0 (no-op).
  - T2: `bus_sel` = ry, `g_in` = 1, `alu_op` from opcode -> T3.
  - T3: `bus_sel` = 8, `r_in[rx]` = 1, `done` = 1 -> T0.
- `alu_op` is 00 in every state except T2.
- Latency from the `run` edge: mv/mvi/illegal = 2 cycles; ALU ops = 4 cycles.
- At most one bit of `r_in` is set; `r_in` is never active together with `ir_in`.
- `run` is ignored outside T0. A held `run` issues back-to-back instructions, with T0 occupying exactly one cycle.
- rx = ry is legal (e.g. add R3,R3 doubles R3).
- `done` and `busy` are never both asserted with `ir_in`.

Decomposition:
- Package `proc_pkg`:
  - opcode localparams (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND)
  - state encoding (T0..T3)
  - bus select codes (SEL_G = 8, SEL_DIN = 9, SEL_NONE = 15)
  - ALU op codes.
- One combinational sub-module, `proc_ir_decode`: splits `ir` into opcode/rx/ry, flags `is_alu`/`is_illegal`, and produces one-hot rx.
- State register and output decode live in `proc_control_fsm`.

Test Plan:
- Reset, `run` = 0 for 5 cycles -> state T0, all enables 0, `bus_sel` = 15, `done` never asserted.
- `run` pulse, IR = 001_010_000 (mvi R2) -> cycle 0 `ir_in` = 1; cycle 1 `bus_sel` = 9, `r_in` = 0000_0100, `done` = 1; idle after.
- IR = 010_001_011 (add R1,R3) -> T1 `bus_sel` = 1, `a_in`; T2 `bus_sel` = 3, `g_in`, `alu_op` = 00; T3 `bus_sel` = 8, `r_in` = 0000_0010, `done`. Datapath with R1 = 5, R3 = 7 ends with R1 = 12.
- IR = 011_000_000 (sub R0,R0) with R0 = 0x1234 -> T2 `alu_op` = 01, R0 = 0x0000 after `done`.
- IR = 111_xxx_xxx -> T1 `done` = 1, no enables, all registers unchanged.
- `reset` asserted in T2 of an add -> next cycle T0, `g_in`/`r_in` never pulse, destination unchanged. `run` held high through three mv instructions -> `done` on cycles 1, 3, 5.
